// File: rtl/seq_multiplier_pkg.sv
// mul_pkg: shared types, default width and count-width helper for the sequential multiplier
package mul_pkg;
    localparam int DEFAULT_WIDTH = 32;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    function automatic int count_width(input int width);
        return $clog2(width + 1);
    endfunction
endpackage

// File: rtl/seq_multiplier_if.sv
// seq_multiplier_if: start/busy/fin handshake with operands and product
interface seq_multiplier_if #(parameter int WIDTH = 32);
    logic               start;
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   mplier;
    logic [2*WIDTH-1:0] prod;
    logic               busy;
    logic               fin;
    modport master (output start, mcand, mplier, input prod, busy, fin);
    modport slave  (input start, mcand, mplier, output prod, busy, fin);
endinterface

// File: rtl/seq_multiplier_step.sv
// mul_step: one shift-and-add iteration; the carry of the add enters the product MSB
module mul_step
    import mul_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [2*WIDTH-1:0] prod,
    input  logic [WIDTH-1:0]   mc,
    output logic [2*WIDTH-1:0] next_prod
);
    logic [WIDTH:0] sum;
    always_comb begin
        sum       = {1'b0, prod[2*WIDTH-1:WIDTH]} + {1'b0, (prod[0] ? mc : {WIDTH{1'b0}})};
        next_prod = {sum, prod[WIDTH-1:1]};
    end
endmodule

// File: rtl/seq_multiplier.sv
// seq_multiplier: unsigned shift-and-add multiplier, one multiplier bit per clock
module seq_multiplier
    import mul_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input logic clk,
    input logic reset,
    seq_multiplier_if.slave bus
);
    localparam int CW = count_width(WIDTH);
    state_t             state, state_next;
    logic [CW-1:0]      count, count_next;
    logic [WIDTH-1:0]   mc_r, mc_next;
    logic [2*WIDTH-1:0] prod_r, prod_next, step_prod;
    logic               accept;

    mul_step #(.WIDTH(WIDTH)) u_step (
        .prod      (prod_r),
        .mc        (mc_r),
        .next_prod (step_prod)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            count  <= '0;
            mc_r   <= '0;
            prod_r <= '0;
        end else begin
            state  <= state_next;
            count  <= count_next;
            mc_r   <= mc_next;
            prod_r <= prod_next;
        end
    end

    // A start in DONE is accepted like one in IDLE, so chained operations have no gap
    always_comb begin
        state_next = state;
        count_next = count;
        mc_next    = mc_r;
        prod_next  = prod_r;
        accept     = (state != RUN) && bus.start;
        if (accept) begin
            state_next = RUN;
            count_next = '0;
            mc_next    = bus.mcand;
            prod_next  = {{WIDTH{1'b0}}, bus.mplier};
        end else if (state == RUN) begin
            prod_next  = step_prod;
            count_next = count + CW'(1);
            state_next = (count == CW'(WIDTH - 1)) ? DONE : RUN;
        end
    end

    assign bus.prod = prod_r;
    assign bus.busy = (state == RUN);
    assign bus.fin  = (state == DONE);
endmodule

// File: tb/tb_seq_multiplier.sv
// tb_seq_multiplier: directed scenario tests for seq_multiplier with hand-computed products
module tb_seq_multiplier;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int checks = 0;
    int errors = 0;

    seq_multiplier_if #(.WIDTH(32)) bus ();
    seq_multiplier #(.WIDTH(32)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic [31:0] a, input logic [31:0] b);
        bus.start  = 1'b1;
        bus.mcand  = a;
        bus.mplier = b;
        step();
        bus.start  = 1'b0;
    endtask

    task automatic wait_fin(output int lat);
        lat = 0;
        while (!bus.fin && lat < 100) begin
            step();
            lat++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.start = 1'b0;
        bus.mcand = '0;
        bus.mplier = '0;
        step();
        step();
        reset = 1'b0;
        checks++; if (bus.prod !== 64'd0) begin errors++; $display("FAIL reset_prod: got %h expected 0", bus.prod); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        checks++; if (bus.fin !== 1'b0) begin errors++; $display("FAIL reset_fin: got %b expected 0", bus.fin); end
    endtask

    task automatic test_basic();
        int lat;
        launch(32'd7, 32'd2);
        checks++; if (bus.busy !== 1'b1 || bus.fin !== 1'b0) begin errors++; $display("FAIL basic_accept: busy=%b fin=%b expected busy=1 fin=0", bus.busy, bus.fin); end
        wait_fin(lat);
        checks++; if (lat !== 32) begin errors++; $display("FAIL basic_latency: got %0d expected 32", lat); end
        checks++; if (bus.prod !== 64'd14) begin errors++; $display("FAIL basic_prod: got %0d expected 14", bus.prod); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL basic_busy_done: got %b expected 0", bus.busy); end
        bus.mcand = 32'hDEAD;
        bus.mplier = 32'hBEEF;
        repeat (5) step();
        checks++; if (bus.prod !== 64'd14 || bus.fin !== 1'b1) begin errors++; $display("FAIL basic_hold: prod=%0d fin=%b expected 14 and 1", bus.prod, bus.fin); end
    endtask

    task automatic test_carry();
        int lat;
        launch(32'hFFFFFFFF, 32'hFFFFFFFF);
        wait_fin(lat);
        checks++; if (bus.prod !== 64'hFFFFFFFE00000001) begin errors++; $display("FAIL carry_prod: got %h expected fffffffe00000001", bus.prod); end
    endtask

    task automatic test_zero_identity();
        int lat;
        launch(32'd0, 32'h12345678);
        wait_fin(lat);
        checks++; if (bus.prod !== 64'd0) begin errors++; $display("FAIL zero_prod: got %h expected 0", bus.prod); end
        launch(32'h12345678, 32'd1);
        wait_fin(lat);
        checks++; if (bus.prod !== 64'h0000000012345678) begin errors++; $display("FAIL identity_prod: got %h expected 0000000012345678", bus.prod); end
    endtask

    task automatic test_start_busy();
        int lat;
        launch(32'd3, 32'd5);
        repeat (9) step();
        launch(32'd9, 32'd9);
        wait_fin(lat);
        checks++; if (lat + 10 !== 32) begin errors++; $display("FAIL busy_start_latency: got %0d expected 32", lat + 10); end
        checks++; if (bus.prod !== 64'd15) begin errors++; $display("FAIL busy_start_prod: got %0d expected 15", bus.prod); end
        repeat (3) step();
        checks++; if (bus.fin !== 1'b1 || bus.busy !== 1'b0) begin errors++; $display("FAIL busy_start_no_second: fin=%b busy=%b expected 1 0", bus.fin, bus.busy); end
    endtask

    task automatic test_reset_mid();
        int lat;
        launch(32'd10, 32'd11);
        repeat (15) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++; if (bus.prod !== 64'd0 || bus.busy !== 1'b0 || bus.fin !== 1'b0) begin errors++; $display("FAIL reset_mid: prod=%h busy=%b fin=%b expected 0 0 0", bus.prod, bus.busy, bus.fin); end
        launch(32'd6, 32'd7);
        wait_fin(lat);
        checks++; if (lat !== 32) begin errors++; $display("FAIL reset_mid_latency: got %0d expected 32", lat); end
        checks++; if (bus.prod !== 64'd42) begin errors++; $display("FAIL reset_mid_prod: got %0d expected 42", bus.prod); end
    endtask

    task automatic test_back_to_back();
        int lat;
        launch(32'd5, 32'd6);
        wait_fin(lat);
        checks++; if (bus.prod !== 64'd30) begin errors++; $display("FAIL b2b_first: got %0d expected 30", bus.prod); end
        launch(32'd100, 32'd200);
        checks++; if (bus.busy !== 1'b1 || bus.fin !== 1'b0) begin errors++; $display("FAIL b2b_no_gap: busy=%b fin=%b expected 1 0", bus.busy, bus.fin); end
        wait_fin(lat);
        checks++; if (lat !== 32) begin errors++; $display("FAIL b2b_latency: got %0d expected 32", lat); end
        checks++; if (bus.prod !== 64'd20000) begin errors++; $display("FAIL b2b_prod: got %0d expected 20000", bus.prod); end
    endtask

    task automatic test_round_trip();
        int lat;
        launch(32'd142, 32'd7);
        wait_fin(lat);
        checks++; if (bus.prod + 64'd6 !== 64'd1000) begin errors++; $display("FAIL round_trip: got %0d expected 1000", bus.prod + 64'd6); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_carry();
        test_zero_identity();
        test_start_busy();
        test_reset_mid();
        test_back_to_back();
        test_round_trip();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/seq_multiplier.md
Name: seq_multiplier

Overview:
- Sequential unsigned shift-and-add multiplier: one multiplier bit per clock, producing a 2*WIDTH product from two WIDTH-bit operands.
- Inverse companion of the sequential divider in the same arithmetic library.
- Intended use: a test bench or datapath rebuilds the dividend as quotient*divisor + remainder.
- Simple start/busy/fin handshake; one operation in flight at a time.

Parameters:
- WIDTH, 32, operand width in bits; product is 2*WIDTH.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- start  input  1  request a multiply; sampled only when not busy
- mcand  input  WIDTH  multiplicand; latched on the accepting edge
- mplier  input  WIDTH  multiplier; latched on the accepting edge
- prod  output  2*WIDTH  product register; valid while fin=1
- busy  output  1  operation in progress
- fin  output  1  product valid; held until the next accepted start or reset

Behaviour:
- Reset: clock clk; reset is synchronous, active-high.
  - Reset values: prod=0, busy=0, fin=0, state=IDLE, count=0.
  - Reset overrides every other input on the same edge.
- States:
  - IDLE: no result available.
  - RUN: iterating.
  - DONE: result held.
- Accept:
  - In IDLE or DONE, start=1 at an edge starts a new operation on that edge.
  - The edge latches mcand into internal mc_r and loads prod={WIDTH'b0, mplier}.
  - It also sets count=0, busy=1, fin=0 and state=RUN.
- RUN iteration, one per edge:
  - sum[WIDTH:0] = prod[2W-1:W] + (prod[0] ? mc_r : 0). The sum is WIDTH+1 bits so the carry is kept.
  - prod <= {sum, prod[W-1:1]}, i.e. a logical right shift with the carry entering the MSB.
  - count <= count+1.
- Completion:
  - The edge on which count goes W-1 -> W sets state=DONE, busy=0 and fin=1.
  - fin therefore rises exactly WIDTH edges after the accepting edge (32 for the default).
- DONE:
  - prod is frozen and fin stays 1.
  - start=1 is accepted per the Accept rule: fin drops and busy rises on the same edge, so back-to-back operations have no idle cycle.
- start during RUN: ignored. It does not affect count, operands or result, and it is not queued.
- Operand changes after the accepting edge: no effect, because operands are latched.
- Reset mid-operation: abort immediately to the reset values. A partial product is never visible with fin=1.
- Arithmetic:
  - Unsigned only; the product never overflows 2*WIDTH bits.
  - count width is clog2(WIDTH+1).
  - No X may propagate out of prod after reset.
- Invariants: busy and fin are never both 1. busy=1 if and only if state=RUN.

Decomposition:
- Package mul_pkg holds:
  - state typedef: IDLE, RUN, DONE
  - default WIDTH constant
  - a count-width helper function.
- Sub-module mul_step: purely combinational, takes {prod, mc_r} and returns the next prod (add plus shift). It is reused by a future radix-4 variant.
- The top level holds the FSM, count, and registers.

Test Plan:
- Basic: reset 2 cycles; mcand=7, mplier=2, start 1 cycle -> busy for 32 cycles, then fin=1 with prod=14; prod stable until the next start.
- Carry path: mcand=mplier=32'hFFFFFFFF -> prod=64'hFFFFFFFE00000001 at fin.
- Zero and identity: 0 x 32'h12345678 -> 0; 32'h12345678 x 1 -> 64'h0000000012345678.
- start while busy: start=1 with new operands at cycle 10 of a 3x5 run -> ignored, prod=15 at the original fin cycle, no second operation.
- Reset mid-op: assert reset at cycle 16 -> next edge prod=0, busy=0, fin=0; a fresh 6x7 operation then yields 42 with full latency.
- Back-to-back plus round trip: start held in DONE chains 100x200 -> 20000 with no gap. Divider outputs (quot, rem[63:32]) for 1000/7 yield prod(142*7)+6=1000.
